gpio_ctrl: RTL and testbench

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_ctrl.sv | 139 +++++++++++++
 tb/tb_gpio_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - GPIO block with OUT/DIR/IN registers, pad synchronizer and optional edge interrupts
// Optional interrupt logic (addresses 5-7, edge detect, irq) is built only when GPIO_CTRL_IRQ_EN is defined.
module gpio_ctrl #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [2:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   localparam logic [2:0] A_OUT  = 3'd0;
   localparam logic [2:0] A_DIR  = 3'd1;
   localparam logic [2:0] A_IN   = 3'd2;
   localparam logic [2:0] A_SET  = 3'd3;
   localparam logic [2:0] A_CLR  = 3'd4;
   localparam logic [2:0] A_MASK = 3'd5;
   localparam logic [2:0] A_STAT = 3'd6;
   localparam logic [2:0] A_EDGE = 3'd7;

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [WIDTH-1:0] wval;
   logic [WIDTH-1:0] in_val;

   assign wval   = wdata[WIDTH-1:0];
   assign in_val = sync_q[SYNC_STAGES-1];

`ifdef GPIO_CTRL_IRQ_EN
   localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] stat_q, stat_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] dly_q, dly_d;
   logic [2:0]       arm_q, arm_d;
   logic             irq_q, irq_d;
   logic [WIDTH-1:0] hit;

   // Edges are ignored until the synchronizer has flushed its reset zeros.
   always_comb begin
      mask_d = mask_q;
      edge_d = edge_q;
      dly_d  = in_val;
      arm_d  = (arm_q == ARM_DONE) ? arm_q : arm_q + 3'd1;
      hit    = (in_val & ~dly_q & edge_q) | (~in_val & dly_q & ~edge_q);
      if (arm_q != ARM_DONE) hit = '0;
      stat_d = stat_q;
      if (wr_en && addr == A_STAT) stat_d = stat_q & ~wval;
      stat_d = stat_d | hit;
      if (wr_en && addr == A_MASK) mask_d = wval;
      if (wr_en && addr == A_EDGE) edge_d = wval;
      irq_d  = |(stat_q & mask_q);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mask_q <= '0;
         stat_q <= '0;
         edge_q <= '0;
         dly_q  <= '0;
         arm_q  <= '0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         stat_q <= stat_d;
         edge_q <= edge_d;
         dly_q  <= dly_d;
         arm_q  <= arm_d;
         irq_q  <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      sync_d[0] = gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      out_d = out_q;
      dir_d = dir_q;
      if (wr_en) begin
         case (addr)
            A_OUT:   out_d = wval;
            A_DIR:   dir_d = wval;
            A_SET:   out_d = out_q | wval;
            A_CLR:   out_d = out_q & ~wval;
            default: ;
         endcase
      end
      // Reads sample pre-write state so a same-cycle write is not visible.
      rdata_d = rdata_q;
      if (rd_en) begin
         case (addr)
            A_OUT:   rdata_d = 32'(out_q);
            A_DIR:   rdata_d = 32'(dir_q);
            A_IN:    rdata_d = 32'(in_val);
`ifdef GPIO_CTRL_IRQ_EN
            A_MASK:  rdata_d = 32'(mask_q);
            A_STAT:  rdata_d = 32'(stat_q);
            A_EDGE:  rdata_d = 32'(edge_q);
`endif
            default: rdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_q   <= '0;
         dir_q   <= '0;
         rdata_q <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         out_q   <= out_d;
         dir_q   <= dir_d;
         rdata_q <= rdata_d;
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      end
   end

   assign gpio_out = out_q;
   assign gpio_oe  = dir_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - self-checking bench for gpio_ctrl against a behavioural register/pad model
module tb_gpio_ctrl;
   localparam int S = 2;
`ifdef GPIO_CTRL_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        wr_en, rd_en;
   logic [2:0]  addr;
   logic [31:0] wdata, pin;
   logic [31:0] rdata, gpio_out, gpio_oe;
   logic        irq;
   logic [31:0] rdata8;
   logic [7:0]  gpio_out8, gpio_oe8;
   logic        irq8;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   logic [31:0] m_out, m_dir, m_mask, m_stat, m_edge, m_in, m_in_prev, m_rdata;
   logic        m_irq;
   logic [31:0] padq[$];
   int          nedge;

   always #5 clk = ~clk;

   gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(S)) dut (
      .clk(clk), .resetn(resetn), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata(wdata), .rdata(rdata), .gpio_in(pin), .gpio_out(gpio_out),
      .gpio_oe(gpio_oe), .irq(irq)
   );

   gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(S)) dut8 (
      .clk(clk), .resetn(resetn), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata(wdata), .rdata(rdata8), .gpio_in(pin[7:0]), .gpio_out(gpio_out8),
      .gpio_oe(gpio_oe8), .irq(irq8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_out = 0; m_dir = 0; m_mask = 0; m_stat = 0; m_edge = 0;
      m_in = 0; m_in_prev = 0; m_rdata = 0; m_irq = 0; nedge = 0;
      padq.delete();
      for (int i = 0; i < S - 1; i++) padq.push_back(32'd0);
   endtask

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0: return m_out;
         3'd1: return m_dir;
         3'd2: return m_in;
         3'd5: return IRQ_EN ? m_mask : 32'd0;
         3'd6: return IRQ_EN ? m_stat : 32'd0;
         3'd7: return IRQ_EN ? m_edge : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Applies one clock edge of register-map semantics to the model.
   task automatic model_edge(input logic we, input logic re, input logic [2:0] a,
                             input logic [31:0] d, input logic [31:0] p);
      logic [31:0] rise, fall, sel;
      nedge++;
      if (re) m_rdata = m_read(a);
      m_irq = IRQ_EN && ((m_stat & m_mask) != 0);
      rise  = m_in & ~m_in_prev;
      fall  = ~m_in & m_in_prev;
      sel   = (rise & m_edge) | (fall & ~m_edge);
      if (nedge < S + 2) sel = 0;
      if (we && a == 3'd6) m_stat = m_stat & ~d;
      m_stat = IRQ_EN ? (m_stat | sel) : 32'd0;
      if (we) begin
         case (a)
            3'd0: m_out = d;
            3'd1: m_dir = d;
            3'd3: m_out = m_out | d;
            3'd4: m_out = m_out & ~d;
            3'd5: if (IRQ_EN) m_mask = d;
            3'd7: if (IRQ_EN) m_edge = d;
            default: ;
         endcase
      end
      padq.push_back(p);
      m_in_prev = m_in;
      m_in = padq.pop_front();
   endtask

   // Drive at negedge, let one posedge happen, compare at the following negedge.
   task automatic tick(input logic we, input logic re, input logic [2:0] a,
                       input logic [31:0] d, input logic [31:0] p);
      wr_en = we; rd_en = re; addr = a; wdata = d; pin = p;
      @(posedge clk);
      model_edge(we, re, a, d, p);
      @(negedge clk);
      chk("gpio_out", gpio_out, m_out);
      chk("gpio_oe", gpio_oe, m_dir);
      chk("rdata", rdata, m_rdata);
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
      wr_en = 0; rd_en = 0;
   endtask

   initial begin
      logic [31:0] p;
      resetn = 0; wr_en = 0; rd_en = 0; addr = 0; wdata = 0; pin = 0;
      p = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_out", gpio_out, 32'd0);
      chk("rst_oe", gpio_oe, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      resetn = 1;

      // OUT/DIR write and readback
      tick(1, 0, 3'd0, 32'hA5A5_A5A5, p);
      chk("out_a5", gpio_out, 32'hA5A5_A5A5);
      tick(1, 0, 3'd1, 32'hFFFF_0000, p);
      chk("oe_ffff", gpio_oe, 32'hFFFF_0000);
      tick(0, 1, 3'd0, 0, p);
      chk("rd_out", rdata, 32'hA5A5_A5A5);
      tick(0, 1, 3'd1, 0, p);
      chk("rd_dir", rdata, 32'hFFFF_0000);
      tick(0, 0, 3'd0, 0, p);
      chk("rd_hold", rdata, 32'hFFFF_0000);

      // SET / CLR
      tick(1, 0, 3'd0, 32'h0000_00F0, p);
      tick(1, 0, 3'd3, 32'h0000_000F, p);
      tick(1, 0, 3'd4, 32'h0000_0030, p);
      chk("setclr", gpio_out, 32'h0000_00CF);
      tick(0, 1, 3'd3, 0, p);
      chk("rd_set", rdata, 32'd0);
      tick(0, 1, 3'd2, 0, p);
      tick(0, 1, 3'd4, 0, p);
      chk("rd_clr", rdata, 32'd0);
      tick(1, 0, 3'd2, 32'hFFFF_FFFF, p);

      // WIDTH=8 truncation, then same-cycle write/read returns old value
      tick(1, 0, 3'd0, 32'hFFFF_FFFF, p);
      chk("out8", {24'd0, gpio_out8}, 32'h0000_00FF);
      tick(0, 1, 3'd0, 0, p);
      chk("rd8", rdata8, 32'h0000_00FF);
      tick(1, 1, 3'd0, 32'h1234_5678, p);
      chk("rw_same", rdata, 32'hFFFF_FFFF);

      // pad synchronizer and edge interrupt
      tick(1, 0, 3'd7, 32'h0000_0009, p);
      tick(1, 0, 3'd5, 32'h0000_0008, p);
      p = 32'h8;
      tick(0, 1, 3'd2, 0, p);
      tick(0, 1, 3'd2, 0, p);
      chk("in_lag", rdata, 32'd0);
      tick(0, 1, 3'd2, 0, p);
      chk("in_bit3", rdata, 32'h8);
      tick(0, 1, 3'd6, 0, p);
      chk("stat8", rdata, IRQ_EN ? 32'h8 : 32'h0);
      chk("irq_set", {31'd0, irq}, {31'd0, IRQ_EN});
      tick(1, 0, 3'd6, 32'h8, p);
      tick(0, 0, 3'd0, 0, p);
      chk("irq_clr", {31'd0, irq}, 32'd0);

      // rising edge on bit 0 coinciding with W1C of bit 0
      p = 32'h9;
      tick(0, 0, 3'd0, 0, p);
      tick(0, 0, 3'd0, 0, p);
      tick(1, 0, 3'd6, 32'h1, p);
      tick(0, 1, 3'd6, 0, p);
      chk("set_wins", rdata & 32'h1, IRQ_EN ? 32'h1 : 32'h0);
      tick(1, 0, 3'd6, 32'hFFFF_FFFF, p);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) p = p ^ (32'd1 << $urandom_range(0, 31));
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom, p);
      end

      // async reset between edges, held across an edge with a write pending
      tick(1, 0, 3'd0, 32'h1, p);
      wr_en = 1; addr = 3'd0; wdata = 32'hFF;
      #2 resetn = 0;
      #1;
      chk("async_rst", gpio_out, 32'd0);
      chk("async_irq", {31'd0, irq}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("abort_wr", gpio_out, 32'd0);
      wr_en = 0;
      resetn = 1;
      model_reset();

      // pads active right after reset: edges must stay masked while flushing
      p = 32'hFFFF_FFFF;
      tick(1, 0, 3'd7, 32'hFFFF_FFFF, p);
      tick(1, 0, 3'd5, 32'hFFFF_FFFF, p);
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 2) == 0) p = $urandom;
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom, p);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
